imm_encoder: RTL
================

Name: imm_encoder

Overview:
- Inverse of the datapath immediate sign extender.
- Takes a base instruction word, a 32-bit signed immediate and an immediate-format select.
- Range- and alignment-checks the immediate, scatters its bits into the I/S/B immediate fields and queues the result in a small output FIFO with valid/ready handshakes.
- Sits between the instruction generator/assembler logic and instruction memory; encoded and error counts are kept for debug.

Parameters:
- DEPTH, 2, output FIFO entries; power of two, >= 2.
- CNT_W, 16, width of the saturating encode and error counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  encoder can accept a request.
- base_instr  input  32  opcode/rd/rs/funct fields; immediate-field bits are ignored and overwritten.
- imm  input  32  two's-complement immediate.
- imm_src  input  2  00 I-type, 01 S-type, 10 B-type, 11 reserved.
- out_valid  output  1  encoded word available.
- out_ready  input  1  consumer takes the word.
- out_instr  output  32  encoded instruction.
- out_err  output  2  0 ok, 1 range, 2 misaligned, 3 bad imm_src.
- clear_cnt  input  1  synchronous counter clear.
- enc_count  output  CNT_W  accepted requests.
- err_count  output  CNT_W  accepted requests with out_err != 0.

Behaviour:
- Reset (async, immediate):
  - FIFO pointers and occupancy = 0.
  - out_valid = 0; out_instr = 0; out_err = 0.
  - enc_count = 0; err_count = 0.
  - in_ready = 1 once rst is low.
- Accept: in_valid && in_ready at a rising edge. Encoding is combinational from the inputs and is written into the FIFO at that edge.
- Latency: out_valid rises the cycle after acceptance when the FIFO was empty. There is no combinational input-to-output path.
- Field mapping (all bits not listed are taken from base_instr):
  - I-type: out_instr[31:20] = imm[11:0].
  - S-type: out_instr[31:25] = imm[11:5]; out_instr[11:7] = imm[4:0].
  - B-type: out_instr[31] = imm[12]; out_instr[7] = imm[11]; out_instr[30:25] = imm[10:5]; out_instr[11:8] = imm[4:1].
- Checks:
  - Range error for I-type and S-type: imm[31:11] are not all equal.
  - Range error for B-type: imm[31:12] are not all equal.
  - Misaligned for B-type: imm[0] = 1.
  - Bad imm_src: imm_src = 11.
  - Priority when several apply: bad src (3) > misaligned (2) > range (1).
- Error entries:
  - out_err = 3: out_instr = base_instr unchanged.
  - out_err = 1 or 2: the field mapping is still applied using the truncated imm bits.
  - Error entries are queued and delivered in order like good ones; they are never dropped.
- Handshake:
  - in_ready = !full; it is a function of registered occupancy only.
  - When full, in_ready stays low even if out_ready = 1 in the same cycle.
  - Pop: out_valid && out_ready.
  - While out_valid && !out_ready, out_instr and out_err hold stable.
  - out_valid stays high until popped.
- Occupancy:
  - Push only: +1. Pop only: -1. Push and pop together (FIFO not full, not empty): unchanged.
  - Read/write pointers wrap modulo DEPTH.
  - Order is strict FIFO.
- Counters:
  - enc_count increments on each accept.
  - err_count increments on each accept with err != 0.
  - Both saturate at all-ones.
  - clear_cnt sets both to 0 at the edge and overrides a same-cycle increment.
- Reset mid-operation: all queued entries are discarded; no out_valid until a new accept.
- Inputs are don't-care while in_valid = 0 or in_ready = 0.

Test Plan:
1. I-type encode: base 0x00000013, imm 0xFFFFF800, src 00.
   -> next cycle out_valid = 1, out_instr = 0x80000013, out_err = 0.
2. S-type encode: base 0x00002023, imm 0x0000007F, src 01 -> out_instr 0x06002FA3, err 0.
   B-type encode: base 0x00000063, imm 0xFFFFFFFC, src 10 -> out_instr 0xFE000EE3, err 0.
3. Error cases:
   - I-type imm 0x00000800 -> err 1.
   - B-type imm 0x00000003 -> err 2.
   - src 11, base 0x12345678 -> out_instr 0x12345678, err 3.
   - Then enc_count = 3, err_count = 3.
4. Backpressure: out_ready = 0, present 3 back-to-back requests.
   -> 2 accepted, then in_ready = 0, and the third is held.
   -> out_instr stable throughout.
   -> raise out_ready: the three words are delivered in order, with no gap once streaming.
5. Streaming: in_valid = out_ready = 1 continuously for 10 requests.
   -> one accept and one pop per cycle after the first; occupancy constant; pointers wrap correctly.
6. Reset and clear:
   - Assert rst with 2 entries queued -> out_valid drops immediately, counters 0, in_ready 1.
   - Assert clear_cnt in the same cycle as an accept -> counters read 0 afterwards.

Source files
------------

// File: rtl/imm_encoder.sv
// Immediate encoder: range/alignment-checks a signed immediate, scatters it into
// the I/S/B immediate fields of a base instruction and queues the word in a FIFO.
module imm_encoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      base_instr,
  input  logic [31:0]      imm,
  input  logic [1:0]       imm_src,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [1:0]       out_err,
  input  logic             clear_cnt,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] OCC_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] OCC_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_RANGE    = 2'd1,
    ERR_MISALIGN = 2'd2,
    ERR_SRC      = 2'd3
  } err_e;

  logic [31:0] enc_instr;
  err_e        enc_err;
  logic        fits_12;
  logic        fits_13;

  logic [31:0]      instr_mem_q [DEPTH];
  logic [1:0]       err_mem_q   [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   occ_q, occ_d;
  logic [CNT_W-1:0] enc_count_q, enc_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             push, pop;

  // A signed value fits N bits when every bit above the sign position matches it.
  assign fits_12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits_13 = (&imm[31:12]) | ~(|imm[31:12]);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    enc_instr = base_instr;
    enc_err   = ERR_OK;
    unique case (imm_src)
      2'b00: begin
        enc_instr[31:20] = imm[11:0];
        if (!fits_12) enc_err = ERR_RANGE;
      end
      2'b01: begin
        enc_instr[31:25] = imm[11:5];
        enc_instr[11:7]  = imm[4:0];
        if (!fits_12) enc_err = ERR_RANGE;
      end
      2'b10: begin
        enc_instr[31]    = imm[12];
        enc_instr[7]     = imm[11];
        enc_instr[30:25] = imm[10:5];
        enc_instr[11:8]  = imm[4:1];
        if (imm[0])        enc_err = ERR_MISALIGN;
        else if (!fits_13) enc_err = ERR_RANGE;
      end
      default: enc_err = ERR_SRC;
    endcase
  end

  assign in_ready  = (occ_q != OCC_FULL);
  assign out_valid = (occ_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Storage is undefined until written; the empty check keeps it off the outputs.
  assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;
  assign out_err   = out_valid ? err_mem_q[rd_ptr_q]   : '0;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    enc_count_d = enc_count_q;
    err_count_d = err_count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
    if (clear_cnt) begin
      enc_count_d = '0;
      err_count_d = '0;
    end else if (push) begin
      if (enc_count_q != '1) enc_count_d = enc_count_q + CNT_ONE;
      if (enc_err != ERR_OK && err_count_q != '1) err_count_d = err_count_q + CNT_ONE;
    end
  end

  // NOTE: the data array has no reset; only pointers and occupancy need one.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= enc_instr;
      err_mem_q[wr_ptr_q]   <= enc_err;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      enc_count_q <= '0;
      err_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      enc_count_q <= enc_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign enc_count = enc_count_q;
  assign err_count = err_count_q;

endmodule
